// File: rtl/r_type_ctrl_pkg.sv
// Shared types and constants for the R-type control sequencer.
package r_type_ctrl_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RADDR_W  = 5;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned SHAMT_W  = 5;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_XNOR = 3'b011,
    ALU_ADD  = 3'b100,
    ALU_SUB  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_SLLV = 3'b111
  } alu_op_e;

  localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_XOR  = 6'b100110;
  localparam logic [FUNCT_W-1:0] FUNCT_XNOR = 6'b100111;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB  = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_SLTU = 6'b101011;
  localparam logic [FUNCT_W-1:0] FUNCT_SLLV = 6'b000100;

  localparam logic [OPCODE_W-1:0] OPCODE_RTYPE = 6'b000000;

  typedef enum logic [1:0] {
    S_IF = 2'd0,
    S_ID = 2'd1,
    S_EX = 2'd2,
    S_WB = 2'd3
  } state_e;

  // R-type instruction word layout
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [RADDR_W-1:0]  rs;
    logic [RADDR_W-1:0]  rt;
    logic [RADDR_W-1:0]  rd;
    logic [SHAMT_W-1:0]  shamt;
    logic [FUNCT_W-1:0]  funct;
  } rtype_inst_t;

  // Decoder result
  typedef struct packed {
    logic    legal;
    alu_op_e op;
  } dec_t;

endpackage

// File: rtl/r_type_ctrl_if.sv
// ALU operand/result interface; the sequencer is the master.
interface r_type_ctrl_if
  import r_type_ctrl_pkg::*;
();

  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_f;
  logic            alu_zf;
  logic            alu_of;

  modport master (
    output alu_a, alu_b, alu_op,
    input  alu_f, alu_zf, alu_of
  );

  modport slave (
    input  alu_a, alu_b, alu_op,
    output alu_f, alu_zf, alu_of
  );

endinterface

// File: rtl/r_type_decoder.sv
// Combinational opcode/funct decode into an ALU op code and a legal bit.
module r_type_decoder
  import r_type_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  output dec_t                dec_c
);

  // Only opcode 0 with a supported funct is legal; everything else maps to AND
  always_comb begin
    dec_c.legal = 1'b0;
    dec_c.op    = ALU_AND;
    if (opcode == OPCODE_RTYPE) begin
      dec_c.legal = 1'b1;
      case (funct)
        FUNCT_AND:  dec_c.op = ALU_AND;
        FUNCT_OR:   dec_c.op = ALU_OR;
        FUNCT_XOR:  dec_c.op = ALU_XOR;
        FUNCT_XNOR: dec_c.op = ALU_XNOR;
        FUNCT_ADD:  dec_c.op = ALU_ADD;
        FUNCT_SUB:  dec_c.op = ALU_SUB;
        FUNCT_SLTU: dec_c.op = ALU_SLTU;
        FUNCT_SLLV: dec_c.op = ALU_SLLV;
        default: begin
          dec_c.legal = 1'b0;
          dec_c.op    = ALU_AND;
        end
      endcase
    end
  end

endmodule

// File: rtl/r_type_ctrl.sv
// Multi-cycle IF/ID/EX/WB sequencer for R-type instructions; owns the PC.
module r_type_ctrl
  import r_type_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic [XLEN-1:0]     inst_addr,
  input  logic                inst_valid,
  input  logic [XLEN-1:0]     inst_data,
  output logic [RADDR_W-1:0]  rf_ra_addr,
  output logic [RADDR_W-1:0]  rf_rb_addr,
  input  logic [XLEN-1:0]     rf_ra_data,
  input  logic [XLEN-1:0]     rf_rb_data,
  output logic                rf_we,
  output logic [RADDR_W-1:0]  rf_w_addr,
  output logic [XLEN-1:0]     rf_w_data,
  r_type_ctrl_if.master       alu,
  output logic                flag_zf,
  output logic                flag_of,
  output logic                illegal,
  output logic                retired
);

  state_e      state_q, state_d;
  rtype_inst_t ir_q;
  logic        legal_q;
  alu_op_e     op_q;
  dec_t        dec_c;
  logic        fetch_c;
  logic        addsub_c;
  logic        unused_fields;

  assign fetch_c       = (state_q == S_IF) && run && inst_valid;
  assign addsub_c      = (op_q == ALU_ADD) || (op_q == ALU_SUB);
  // rs/rt are forwarded to the register file at fetch time; shamt is not used
  assign unused_fields = ^{ir_q.rs, ir_q.rt, ir_q.shamt};

  r_type_decoder u_dec (
    .opcode (ir_q.opcode),
    .funct  (ir_q.funct),
    .dec_c  (dec_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:    if (fetch_c) state_d = S_ID;
      S_ID:    state_d = S_EX;
      S_EX:    state_d = S_WB;
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // Datapath registers and registered outputs, updated on state transitions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_addr  <= PC_RESET;
      ir_q       <= '0;
      legal_q    <= 1'b0;
      op_q       <= ALU_AND;
      rf_ra_addr <= '0;
      rf_rb_addr <= '0;
      rf_we      <= 1'b0;
      rf_w_addr  <= '0;
      rf_w_data  <= '0;
      alu.alu_a  <= '0;
      alu.alu_b  <= '0;
      alu.alu_op <= ALU_AND;
      flag_zf    <= 1'b0;
      flag_of    <= 1'b0;
      illegal    <= 1'b0;
      retired    <= 1'b0;
    end else begin
      rf_we   <= 1'b0;
      illegal <= 1'b0;
      retired <= 1'b0;
      case (state_q)
        S_IF: begin
          if (fetch_c) begin
            ir_q       <= rtype_inst_t'(inst_data);
            inst_addr  <= inst_addr + XLEN'(PC_STEP);
            rf_ra_addr <= inst_data[25:21];
            rf_rb_addr <= inst_data[20:16];
          end
        end
        S_ID: begin
          alu.alu_a  <= rf_ra_data;
          alu.alu_b  <= rf_rb_data;
          alu.alu_op <= dec_c.op;
          op_q       <= dec_c.op;
          legal_q    <= dec_c.legal;
        end
        S_EX: begin
          alu.alu_op <= ALU_AND;
          rf_w_addr  <= ir_q.rd;
          rf_w_data  <= alu.alu_f;
          if (legal_q) begin
            flag_zf <= alu.alu_zf;
            flag_of <= alu.alu_of;
          end
          // Suppress write for illegal ops, rd=0 and overflowing add/sub
          rf_we   <= legal_q && (ir_q.rd != '0) && !(addsub_c && alu.alu_of);
          illegal <= !legal_q;
          retired <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/r_type_ctrl.md
Name: r_type_ctrl

Overview:
- Multi-cycle control/datapath sequencer for the R-type CPU; it is the initiator side of the ALU interface.
- Fetches a 32-bit instruction, decodes opcode/funct into the 3-bit ALU_OP code, and reads rs/rt from the register file.
- Presents rs/rt data to the ALU, captures F/ZF/OF, and writes the result back to rd.
- Sits between instruction memory, the register file and the ALU, and owns the PC.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, PC increment per retired instruction

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  1 = allow fetching; sampled only in S_IF
inst_addr  out  32  current PC to instruction memory
inst_valid  in  1  inst_data valid this cycle
inst_data  in  32  instruction word
rf_ra_addr  out  5  register file read port A address (rs)
rf_rb_addr  out  5  register file read port B address (rt)
rf_ra_data  in  32  combinational read data A
rf_rb_data  in  32  combinational read data B
rf_we  out  1  register file write enable, 1-cycle pulse
rf_w_addr  out  5  write address (rd)
rf_w_data  out  32  write data
alu_a  out  32  ALU operand A (rs data)
alu_b  out  32  ALU operand B (rt data)
alu_op  out  3  ALU operation code
alu_f  in  32  ALU result
alu_zf  in  1  ALU zero flag
alu_of  in  1  ALU overflow flag (valid for add/sub only)
flag_zf  out  1  registered ZF of last executed instruction
flag_of  out  1  registered OF of last executed instruction
illegal  out  1  1-cycle pulse: unsupported instruction retired
retired  out  1  1-cycle pulse: any instruction completed WB

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=S_IF, PC=PC_RESET, IR=0, operand/result registers=0.
  - All outputs 0 except inst_addr=PC_RESET.
  - Reset asserted mid-instruction abandons the instruction; no rf_we is issued.
- State machine: S_IF -> S_ID -> S_EX -> S_WB -> S_IF. Latency is 4 cycles per instruction when inst_valid is already high in S_IF.
- S_IF:
  - If run=1 and inst_valid=1: IR<=inst_data, PC<=PC+PC_STEP (32-bit wrap), go to S_ID.
  - Otherwise hold state and PC.
- S_ID:
  - rf_ra_addr=IR[25:21], rf_rb_addr=IR[20:16].
  - Latch rf_ra_data->A_reg and rf_rb_data->B_reg.
  - Decode into op_reg and a legal bit.
  - Legal only when IR[31:26]=6'b000000 and funct is one of:
    - 100100 and -> 000
    - 100101 or -> 001
    - 100110 xor -> 010
    - 100111 xnor -> 011
    - 100000 add -> 100
    - 100010 sub -> 101
    - 101011 sltu -> 110
    - 000100 sllv -> 111
  - Any other opcode/funct: legal=0, op_reg=000.
- S_EX:
  - alu_a=A_reg, alu_b=B_reg, alu_op=op_reg (alu_op is 000 in all other states).
  - Latch alu_f->F_reg. Latch alu_zf->flag_zf and alu_of->flag_of, but only if legal; otherwise both flags are unchanged.
- S_WB:
  - retired=1 for one cycle.
  - rf_we=1 only if legal AND rd (IR[15:11]) != 0 AND NOT (op is add/sub AND flag_of=1).
  - When written: rf_w_addr=rd, rf_w_data=F_reg.
  - illegal=1 if legal=0.
  - Always return to S_IF.
- Boundaries:
  - rd=0: no write; flags still update.
  - Overflowing add/sub: no write; flag_of stays 1 until the next legal instruction.
  - sllv with A_reg>=32: write F_reg as delivered by the ALU; no masking in this block.
  - PC 32'hFFFF_FFFC + 4 wraps to 0.
  - run deasserted mid-instruction: has no effect until the next S_IF.

Decomposition:
- Shared package holds:
  - ALU_OP constants (AND, OR, XOR, XNOR, ADD, SUB, SLTU, SLLV).
  - Funct constants.
  - R-type opcode 6'b000000.
  - State encoding S_IF/S_ID/S_EX/S_WB.
- One natural sub-module: r_type_decoder (combinational, IR -> {legal, alu_op}). The FSM and registers stay in r_type_ctrl.

Test Plan:
- Reset then run=1, inst_valid=1, add $3,$1,$2 with $1=5, $2=7 -> alu_op=100 in S_EX; rf_we pulse with addr 3, data 12; flag_zf=0; PC=4 after S_IF.
- sub $4,$1,$1 with $1=9 -> rf_w_data=0, flag_zf=1, retired pulse 4 cycles after fetch.
- add with $1=32'h7FFF_FFFF, $2=1 -> flag_of=1, rf_we stays 0.
- sllv $5,$6,$7 with rs=$6=4, rt=$7=3 -> alu_a=4, alu_b=3, rf_w_data=48. Then or $0,$6,$7 -> no rf_we, flag_zf=0.
- opcode 6'b100011 (lw) -> illegal pulse in S_WB, no rf_we, flags unchanged, PC advanced by 4.
- rst_n pulled low during S_EX -> no rf_we, PC=PC_RESET immediately. run=0 after release -> state stays S_IF, PC constant.
